// File: rtl/piece_bag_queue.sv
// 7-bag tetromino source: LFSR-driven picks feed a 3-entry lookahead queue
// whose head is the next piece to spawn and whose tail drives the preview.
module piece_bag_queue #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8,
    parameter logic [2:0]  START_IDX = 3'd5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       new_block,
    input  logic [2:0] new_move,
    output logic [2:0] block_idx,
    output logic [5:0] next_preview,
    output logic       queue_valid,
    output logic       queue_full,
    output logic       underflow
);

    typedef enum logic {S_IDLE, S_PICK} state_t;

    localparam logic [6:0]  MASK_FULL  = 7'h7F;
    localparam logic [6:0]  MASK_START = MASK_FULL & ~(7'd1 << START_IDX);
    localparam logic [3:0]  TRY_LIMIT  = 4'(MAX_TRIES - 1);
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_lfsr;
    logic [2:0][2:0]  r_q;
    logic [1:0]       r_count;
    logic [6:0]       r_mask;
    logic [3:0]       r_tries;
    logic             r_underflow;

    logic [15:0]      w_lfsr_mixed;
    logic [15:0]      w_lfsr_next;
    logic [2:0]       w_cand;
    logic [7:0]       w_mask8;
    logic             w_cand_ok;
    logic             w_push;
    logic [2:0]       w_pick;
    logic [3:0]       w_tries_next;
    logic             w_pop;
    logic [1:0]       w_push_idx;
    logic [2:0][2:0]  w_q_next;
    logic [1:0]       w_count_next;
    logic [6:0]       w_mask_clr;
    logic [6:0]       w_mask_next;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [2:0] lowest_set(input logic [6:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // An all-zero LFSR would lock up, so that case reloads the seed.
    always_comb begin
        w_lfsr_mixed = lfsr_step(r_lfsr) ^ {13'b0, new_move};
        w_lfsr_next  = (w_lfsr_mixed == 16'd0) ? SEED : w_lfsr_mixed;
    end

    // Bit 7 of the widened mask is always zero, so candidate 7 is rejected.
    always_comb begin
        w_cand    = r_lfsr[2:0];
        w_mask8   = {1'b0, r_mask};
        w_cand_ok = w_mask8[w_cand];
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pick       = w_cand;
        w_tries_next = r_tries;
        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd3) w_state_next = S_PICK;
            end
            S_PICK: begin
                if (w_cand_ok) begin
                    w_push       = 1'b1;
                    w_tries_next = 4'd0;
                    w_state_next = S_IDLE;
                end else if (r_tries + 4'd1 == TRY_LIMIT) begin
                    w_push       = 1'b1;
                    w_pick       = lowest_set(r_mask);
                    w_tries_next = 4'd0;
                    w_state_next = S_IDLE;
                end else begin
                    w_tries_next = r_tries + 4'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pop shifts first; a simultaneous push lands just behind the survivors.
    always_comb begin
        w_pop      = new_block && (r_count != 2'd0);
        w_push_idx = w_pop ? (r_count - 2'd1) : r_count;
        w_q_next   = r_q;
        if (w_pop) begin
            w_q_next[0] = r_q[1];
            w_q_next[1] = r_q[2];
        end
        if (w_push) begin
            case (w_push_idx)
                2'd0:    w_q_next[0] = w_pick;
                2'd1:    w_q_next[1] = w_pick;
                2'd2:    w_q_next[2] = w_pick;
                default: w_q_next    = w_q_next;
            endcase
        end
        w_count_next = r_count;
        if (w_push && !w_pop) w_count_next = r_count + 2'd1;
        if (w_pop && !w_push) w_count_next = r_count - 2'd1;
        w_mask_clr  = r_mask & ~(7'd1 << w_pick);
        w_mask_next = r_mask;
        if (w_push) w_mask_next = (w_mask_clr == 7'd0) ? MASK_FULL : w_mask_clr;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED;
            r_q         <= {START_IDX, START_IDX, START_IDX};
            r_count     <= 2'd0;
            r_mask      <= MASK_START;
            r_tries     <= 4'd0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_q         <= w_q_next;
            r_count     <= w_count_next;
            r_mask      <= w_mask_next;
            r_tries     <= w_tries_next;
            if (new_block && (r_count == 2'd0)) r_underflow <= 1'b1;
            assert (!(w_push && (r_count == 2'd3) && !w_pop));
        end
    end

    assign block_idx    = r_q[0];
    assign next_preview = {r_q[2], r_q[1]};
    assign queue_valid  = (r_count != 2'd0);
    assign queue_full   = (r_count == 2'd3);
    assign underflow    = r_underflow;

endmodule
